conv3x3_stream_engine: RTL and testbench



---
 rtl/conv3x3_stream_engine.sv | 148 ++++++++++++++
 tb/tb_conv3x3_stream_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution: raster-order pixels in, one signed result per
// fully populated window out, two cycles after the completing pixel.
module conv3x3_stream_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUT_WIDTH    = 32,
  parameter int IMG_WIDTH    = 28,
  parameter int IMG_HEIGHT   = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [9*WEIGHT_WIDTH-1:0] i_weights,
  output logic [OUT_WIDTH-1:0]      m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  // Product of a zero-extended pixel and a signed weight, then 9-way sum.
  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH + 1;
  localparam int SW = PW + 4;
  localparam int AW = (SW > OUT_WIDTH) ? SW : OUT_WIDTH;

  logic                    w_beat;
  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic [DATA_WIDTH-1:0]   r_lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]   r_lb2 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]   w_lb1;
  logic [DATA_WIDTH-1:0]   w_lb2;
  logic [DATA_WIDTH-1:0]   r_win [9];
  logic                    r_wvalid;
  logic                    r_wlast;
  logic signed [WEIGHT_WIDTH-1:0] w_wt [9];
  logic signed [PW-1:0]    r_prod [9];
  logic                    r_pvalid;
  logic                    r_plast;
  logic signed [AW-1:0]    w_sum;
  logic                    w_unused;

  assign s_axis_tready = 1'b1;
  assign w_beat        = s_axis_tvalid;
  assign w_unused      = m_axis_tready;

  // Raster position of the beat being accepted this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_beat) begin
      if (r_col == CW'(IMG_WIDTH - 1)) begin
        r_col <= '0;
        if (r_row == RW'(IMG_HEIGHT - 1)) r_row <= '0;
        else                              r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Line buffers indexed by column: reading slot col yields the pixel of the
  // same column one (lb1) and two (lb2) rows up, equivalent to depth-W FIFOs.
  assign w_lb1 = r_lb1[r_col];
  assign w_lb2 = r_lb2[r_col];

  // Line buffer update; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_lb1[r_col] <= s_axis_tdata;
      r_lb2[r_col] <= w_lb1;
    end
  end

  // Window shift-left with new right column, plus window valid/last flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < 9; k++) r_win[k] <= '0;
      r_wvalid <= 1'b0;
      r_wlast  <= 1'b0;
    end else begin
      r_wvalid <= w_beat && (r_row >= RW'(2)) && (r_col >= CW'(2));
      r_wlast  <= w_beat && (r_row == RW'(IMG_HEIGHT - 1)) &&
                  (r_col == CW'(IMG_WIDTH - 1));
      if (w_beat) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= w_lb2;
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[5] <= w_lb1;
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[8] <= s_axis_tdata;
      end
    end
  end

  // Unpack kernel taps.
  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      w_wt[k] = i_weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  // Multiply stage: one signed product per tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < 9; k++) r_prod[k] <= '0;
      r_pvalid <= 1'b0;
      r_plast  <= 1'b0;
    end else begin
      r_pvalid <= r_wvalid;
      r_plast  <= r_wlast;
      if (r_wvalid) begin
        for (int unsigned k = 0; k < 9; k++) begin
          r_prod[k] <= PW'($signed({1'b0, r_win[k]})) * PW'(w_wt[k]);
        end
      end
    end
  end

  // Full-precision sum of the nine products.
  always_comb begin
    w_sum = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      w_sum = w_sum + AW'(r_prod[k]);
    end
  end

  // Output register; data holds while no result is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      m_axis_tvalid <= r_pvalid;
      m_axis_tlast  <= r_plast;
      if (r_pvalid) m_axis_tdata <= w_sum[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Self-checking bench: direct 2-D convolution model vs. streamed results.
module tb_conv3x3_stream_engine;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NOUT = (W - 2) * (H - 2);

  logic        clk;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [71:0] i_weights;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  conv3x3_stream_engine #(
    .DATA_WIDTH  (8),
    .WEIGHT_WIDTH(8),
    .OUT_WIDTH   (32),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .i_weights    (i_weights),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int img [H][W];
  int wt  [9];

  longint exp_data [$];
  int     exp_last [$];
  int     exp_edge [$];
  longint got_d [NOUT + 64];
  int     got_n = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint conv_at(input int r, input int c);
    longint s = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        s += longint'(img[r-2+dr][c-2+dc]) * longint'(wt[dr*3+dc]);
    return s;
  endfunction

  task automatic load_weights();
    for (int k = 0; k < 9; k++) i_weights[k*8 +: 8] = 8'(wt[k]);
  endtask

  // Output monitor: every valid result must match the next expected window.
  always @(negedge clk) begin
    if (m_axis_tvalid) begin
      if (exp_data.size() == 0) begin
        check("spurious_tvalid", 1, 0);
      end else begin
        longint e_d;
        int     e_l;
        int     e_e;
        e_d = exp_data.pop_front();
        e_l = exp_last.pop_front();
        e_e = exp_edge.pop_front();
        check("data", longint'($signed(m_axis_tdata)), e_d);
        check("tlast", longint'(m_axis_tlast), longint'(e_l));
        check("latency", longint'(cyc), longint'(e_e + 2));
        if (got_n < NOUT + 64) got_d[got_n] = longint'($signed(m_axis_tdata));
        got_n++;
      end
    end
  end

  // Stream up to n_pix pixels of img in raster order, idling gap_pct% of slots.
  task automatic send_frame(input int gap_pct, input int n_pix);
    int sent = 0;
    got_n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (sent < n_pix) begin
          while ($urandom_range(0, 99) < gap_pct) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
          end
          @(negedge clk);
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = 8'(img[r][c]);
          if (r >= 2 && c >= 2) begin
            exp_data.push_back(conv_at(r, c));
            exp_last.push_back((r == H - 1 && c == W - 1) ? 1 : 0);
            exp_edge.push_back(cyc + 1);
          end
          sent++;
        end
      end
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain_and_count(input string tag);
    for (int i = 0; i < 20 && exp_data.size() > 0; i++) @(negedge clk);
    check({tag, "_drain"}, longint'(exp_data.size()), 0);
    check({tag, "_count"}, longint'(got_n), longint'(NOUT));
  endtask

  task automatic set_edge_kernel();
    for (int k = 0; k < 9; k++) wt[k] = -1;
    wt[4] = 8;
    load_weights();
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = (r * W + c) % 256;
  endtask

  initial begin
    rst           = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    i_weights     = '0;
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tvalid", longint'(m_axis_tvalid), 0);
    check("rst_tdata", longint'(m_axis_tdata), 0);
    check("rst_tlast", longint'(m_axis_tlast), 0);
    check("tready", longint'(s_axis_tready), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Edge kernel over a flat image: all results zero.
    set_edge_kernel();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 10;
    send_frame(0, W * H);
    drain_and_count("flat");

    // Single bright pixel at (5,5).
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 0;
    img[5][5] = 255;
    send_frame(0, W * H);
    drain_and_count("impulse");
    check("impulse_centre", got_d[4 * (W - 2) + 4], 2040);
    check("impulse_nbr_tl", got_d[3 * (W - 2) + 3], -255);
    check("impulse_nbr_br", got_d[5 * (W - 2) + 5], -255);
    check("impulse_far", got_d[0], 0);

    // Saturated pixels and weights.
    for (int k = 0; k < 9; k++) wt[k] = 127;
    load_weights();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 255;
    send_frame(0, W * H);
    drain_and_count("max");
    check("max_first", got_d[0], 291465);
    check("max_last", got_d[NOUT - 1], 291465);

    // Identity kernel on the ramp, gap-free then with random gaps.
    for (int k = 0; k < 9; k++) wt[k] = 0;
    wt[4] = 1;
    load_weights();
    fill_ramp();
    send_frame(0, W * H);
    drain_and_count("ident");
    check("ident_first", got_d[0], 29);
    send_frame(50, W * H);
    drain_and_count("ident_gaps");

    // Random image and kernel.
    for (int k = 0; k < 9; k++) wt[k] = int'($urandom_range(0, 255)) - 128;
    load_weights();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
    send_frame(25, W * H);
    drain_and_count("random");

    // Reset mid-frame after 300 pixels, then a full frame.
    set_edge_kernel();
    fill_ramp();
    send_frame(0, 300);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_data.delete();
    exp_last.delete();
    exp_edge.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_tvalid", longint'(m_axis_tvalid), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("postrst_tvalid", longint'(m_axis_tvalid), 0);
    end
    send_frame(0, W * H);
    drain_and_count("after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
